// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save accumulator: FSM state encoding,
// default widths and the signed saturation helper used at resolve time.
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } csa_state_t;

    localparam int DEF_IN_WIDTH  = 16;
    localparam int DEF_ACC_WIDTH = 40;
    localparam int DEF_OUT_WIDTH = 32;
    localparam int DEF_CNT_WIDTH = 16;

    // Widest resolved total the saturation helper handles; ACC_WIDTH must not exceed it.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic             overflow;
        logic [SAT_W-1:0] value;
    } sat_result_t;

    // Clamp a signed total into the signed range of out_width bits and flag
    // whether clamping was needed.
    function automatic sat_result_t saturate_signed(input logic signed [SAT_W-1:0] total,
                                                    input int out_width);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sat_result_t             res;
        max_v = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (total > max_v) begin
            res.overflow = 1'b1;
            res.value    = max_v;
        end else if (total < min_v) begin
            res.overflow = 1'b1;
            res.value    = min_v;
        end else begin
            res.overflow = 1'b0;
            res.value    = total;
        end
        return res;
    endfunction

endpackage

// File: rtl/csa_accumulator_if.sv
// Operand stream in, resolved result out.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the sender holds data/last stable while valid is high and ready is low,
// and valid never waits on ready. state is a debug view of the accumulator FSM.
interface csa_accumulator_if
    import csa_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) ();
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_overflow;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_valid;
    logic                 out_ready;
    csa_state_t           state;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_overflow, out_count, out_valid, state
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_overflow, out_count, out_valid, state
    );
endinterface

// File: rtl/csa_row.sv
// One 3:2 compressor row: a column of independent full adders. Produces raw
// per-bit sum and majority vectors; the caller applies the carry shift.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module csa_row #(
    parameter int WIDTH = 40
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] maj
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fullAdder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .sum (sum[i]),
            .cout(maj[i])
        );
    end
endmodule

// File: rtl/csa_accumulator.sv
// Streaming signed accumulator. The running total lives in redundant
// sum/carry form so the per-operand loop is a single full-adder level; the
// carry-propagate add happens once per group in RESOLVE.
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int SATURATE  = 1,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input logic              clk,
    input logic              reset,
    csa_accumulator_if.slave bus
);
    csa_state_t                  state;
    logic [ACC_WIDTH-1:0]        acc_sum;
    logic [ACC_WIDTH-1:0]        acc_carry;
    logic [ACC_WIDTH-1:0]        operand_ext;
    logic [ACC_WIDTH-1:0]        row_sum;
    logic [ACC_WIDTH-1:0]        row_maj;
    logic signed [ACC_WIDTH-1:0] total;
    logic [CNT_WIDTH-1:0]        term_count;
    logic [CNT_WIDTH-1:0]        out_count_r;
    logic [OUT_WIDTH-1:0]        out_data_r;
    logic [OUT_WIDTH-1:0]        res_data;
    logic                        out_overflow_r;
    logic                        out_valid_r;
    logic                        in_ready_r;
    sat_result_t                 sat_res;
    logic                        unused_bits;

    assign operand_ext = ACC_WIDTH'($signed(bus.in_data));

    csa_row #(.WIDTH(ACC_WIDTH)) u_row (
        .a  (acc_sum),
        .b  (acc_carry),
        .c  (operand_ext),
        .sum(row_sum),
        .maj(row_maj)
    );

    assign total = $signed(acc_sum + acc_carry);

    // Resolve the redundant total and pick clamped or truncated output.
    always_comb begin
        sat_res  = saturate_signed(SAT_W'(total), OUT_WIDTH);
        res_data = total[OUT_WIDTH-1:0];
        if (SATURATE != 0) begin
            res_data = sat_res.value[OUT_WIDTH-1:0];
        end
    end

    // Top majority bit falls off the modular accumulator; helper bits beyond OUT_WIDTH are not needed.
    assign unused_bits = ^{row_maj[ACC_WIDTH-1], sat_res.value};

    // Group FSM: accumulate, resolve once, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ACCUM;
            acc_sum        <= '0;
            acc_carry      <= '0;
            term_count     <= '0;
            out_data_r     <= '0;
            out_count_r    <= '0;
            out_overflow_r <= 1'b0;
            out_valid_r    <= 1'b0;
            in_ready_r     <= 1'b1;
        end else begin
            case (state)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_sum   <= row_sum;
                        acc_carry <= {row_maj[ACC_WIDTH-2:0], 1'b0};
                        if (term_count != '1) begin
                            term_count <= term_count + 1'b1;
                        end
                        if (bus.in_last) begin
                            state      <= RESOLVE;
                            in_ready_r <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    out_data_r     <= res_data;
                    out_overflow_r <= sat_res.overflow;
                    out_count_r    <= term_count;
                    out_valid_r    <= 1'b1;
                    acc_sum        <= '0;
                    acc_carry      <= '0;
                    term_count     <= '0;
                    state          <= OUTPUT;
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= ACCUM;
                    end
                end
                default: begin
                    state      <= ACCUM;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_r;
    assign bus.out_data     = out_data_r;
    assign bus.out_overflow = out_overflow_r;
    assign bus.out_count    = out_count_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.state        = state;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator: a default-width instance for the group
// flow and two 16-bit-output instances (saturating and truncating) for overflow.
module tb_csa_accumulator;
    import csa_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    csa_accumulator_if #(.IN_WIDTH(16), .OUT_WIDTH(32), .CNT_WIDTH(16)) m_if ();
    csa_accumulator_if #(.IN_WIDTH(16), .OUT_WIDTH(16), .CNT_WIDTH(16)) s_if ();
    csa_accumulator_if #(.IN_WIDTH(16), .OUT_WIDTH(16), .CNT_WIDTH(16)) t_if ();

    csa_accumulator #(
        .IN_WIDTH(16), .ACC_WIDTH(40), .OUT_WIDTH(32), .SATURATE(1), .CNT_WIDTH(16)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (m_if.slave)
    );

    csa_accumulator #(
        .IN_WIDTH(16), .ACC_WIDTH(40), .OUT_WIDTH(16), .SATURATE(1), .CNT_WIDTH(16)
    ) u_sat (
        .clk  (clk),
        .reset(reset),
        .bus  (s_if.slave)
    );

    csa_accumulator #(
        .IN_WIDTH(16), .ACC_WIDTH(40), .OUT_WIDTH(16), .SATURATE(0), .CNT_WIDTH(16)
    ) u_trunc (
        .clk  (clk),
        .reset(reset),
        .bus  (t_if.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        m_if.in_data  = d;
        m_if.in_valid = 1'b1;
        m_if.in_last  = last;
        step();
        m_if.in_valid = 1'b0;
        m_if.in_last  = 1'b0;
    endtask

    task automatic send_sat(input logic [15:0] d, input logic last);
        s_if.in_data  = d;
        s_if.in_valid = 1'b1;
        s_if.in_last  = last;
        t_if.in_data  = d;
        t_if.in_valid = 1'b1;
        t_if.in_last  = last;
        step();
        s_if.in_valid = 1'b0;
        s_if.in_last  = 1'b0;
        t_if.in_valid = 1'b0;
        t_if.in_last  = 1'b0;
    endtask

    task automatic handshake();
        m_if.out_ready = 1'b1;
        step();
        m_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_checks++;
        if (m_if.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", m_if.in_ready);
        else n_pass++;
        n_checks++;
        if (m_if.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", m_if.out_valid);
        else n_pass++;
        n_checks++;
        if (m_if.out_data !== 32'd0) $display("FAIL reset_out_data got %0h want 0", m_if.out_data);
        else n_pass++;
        n_checks++;
        if (m_if.out_count !== 16'd0) $display("FAIL reset_out_count got %0d want 0", m_if.out_count);
        else n_pass++;
        n_checks++;
        if (m_if.out_overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", m_if.out_overflow);
        else n_pass++;
        n_checks++;
        if (m_if.state !== ACCUM) $display("FAIL reset_state got %0d want %0d", m_if.state, ACCUM);
        else n_pass++;
    endtask

    task automatic test_plain_group();
        send(16'd5, 1'b0);
        send(-16'sd3, 1'b0);
        send(16'd100, 1'b1);
        // One cycle in RESOLVE before the result appears.
        n_checks++;
        if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b0)
            $display("FAIL plain_resolve_cycle got valid=%0b ready=%0b want valid=0 ready=0",
                     m_if.out_valid, m_if.in_ready);
        else n_pass++;
        step();
        n_checks++;
        if (m_if.out_valid !== 1'b1) $display("FAIL plain_valid got %0b want 1", m_if.out_valid);
        else n_pass++;
        n_checks++;
        if (m_if.out_data !== 32'd102) $display("FAIL plain_data got %0d want 102", $signed(m_if.out_data));
        else n_pass++;
        n_checks++;
        if (m_if.out_count !== 16'd3 || m_if.out_overflow !== 1'b0)
            $display("FAIL plain_count_ovf got count=%0d ovf=%0b want count=3 ovf=0",
                     m_if.out_count, m_if.out_overflow);
        else n_pass++;
        handshake();
        n_checks++;
        if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b1)
            $display("FAIL plain_release got valid=%0b ready=%0b want valid=0 ready=1",
                     m_if.out_valid, m_if.in_ready);
        else n_pass++;
    endtask

    task automatic test_saturation();
        s_if.out_ready = 1'b0;
        t_if.out_ready = 1'b0;
        send_sat(16'h7FFF, 1'b0);
        send_sat(16'h7FFF, 1'b0);
        send_sat(16'h7FFF, 1'b1);
        step();
        n_checks++;
        if (s_if.out_data !== 16'h7FFF || s_if.out_overflow !== 1'b1)
            $display("FAIL sat_pos got data=%0h ovf=%0b want data=7fff ovf=1",
                     s_if.out_data, s_if.out_overflow);
        else n_pass++;
        n_checks++;
        if (t_if.out_data !== 16'h7FFD || t_if.out_overflow !== 1'b1)
            $display("FAIL trunc_pos got data=%0h ovf=%0b want data=7ffd ovf=1",
                     t_if.out_data, t_if.out_overflow);
        else n_pass++;
        s_if.out_ready = 1'b1;
        t_if.out_ready = 1'b1;
        step();
        s_if.out_ready = 1'b0;
        t_if.out_ready = 1'b0;
        send_sat(16'h8000, 1'b0);
        send_sat(16'h8000, 1'b0);
        send_sat(16'h8000, 1'b1);
        step();
        n_checks++;
        if (s_if.out_data !== 16'h8000 || s_if.out_overflow !== 1'b1)
            $display("FAIL sat_neg got data=%0h ovf=%0b want data=8000 ovf=1",
                     s_if.out_data, s_if.out_overflow);
        else n_pass++;
        // -98304 = 0x...E8000, low 16 bits are 0x8000.
        n_checks++;
        if (t_if.out_data !== 16'h8000 || t_if.out_overflow !== 1'b1 || t_if.out_count !== 16'd3)
            $display("FAIL trunc_neg got data=%0h ovf=%0b count=%0d want data=8000 ovf=1 count=3",
                     t_if.out_data, t_if.out_overflow, t_if.out_count);
        else n_pass++;
        s_if.out_ready = 1'b1;
        t_if.out_ready = 1'b1;
        step();
        s_if.out_ready = 1'b0;
        t_if.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        send(16'd1, 1'b0);
        send(16'd2, 1'b1);
        step();
        // Next group's operand waits upstream while the result is held.
        m_if.in_data  = 16'd9;
        m_if.in_valid = 1'b1;
        m_if.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (m_if.in_ready !== 1'b0 || m_if.out_valid !== 1'b1 ||
                m_if.out_data !== 32'd3 || m_if.out_count !== 16'd2)
                $display("FAIL backpressure_hold[%0d] got ready=%0b valid=%0b data=%0d count=%0d want 0 1 3 2",
                         i, m_if.in_ready, m_if.out_valid, m_if.out_data, m_if.out_count);
            else n_pass++;
            step();
        end
        handshake();
        n_checks++;
        if (m_if.state !== ACCUM || m_if.in_ready !== 1'b1)
            $display("FAIL backpressure_release got state=%0d ready=%0b want %0d 1",
                     m_if.state, m_if.in_ready, ACCUM);
        else n_pass++;
        step();
        m_if.in_valid = 1'b0;
        m_if.in_last  = 1'b0;
        step();
        n_checks++;
        if (m_if.out_valid !== 1'b1 || m_if.out_data !== 32'd9 || m_if.out_count !== 16'd1)
            $display("FAIL backpressure_next got valid=%0b data=%0d count=%0d want 1 9 1",
                     m_if.out_valid, m_if.out_data, m_if.out_count);
        else n_pass++;
        handshake();
    endtask

    task automatic test_back_to_back();
        m_if.out_ready = 1'b1;
        send(-16'sd7, 1'b1);
        step();
        n_checks++;
        if (m_if.out_valid !== 1'b1 || m_if.out_data !== 32'hFFFF_FFF9 || m_if.out_count !== 16'd1)
            $display("FAIL b2b_single got valid=%0b data=%0h count=%0d want 1 fffffff9 1",
                     m_if.out_valid, m_if.out_data, m_if.out_count);
        else n_pass++;
        step();
        n_checks++;
        if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b1)
            $display("FAIL b2b_turnaround got valid=%0b ready=%0b want 0 1",
                     m_if.out_valid, m_if.in_ready);
        else n_pass++;
        send(16'd1, 1'b0);
        send(16'd2, 1'b1);
        step();
        n_checks++;
        if (m_if.out_valid !== 1'b1 || m_if.out_data !== 32'd3 || m_if.out_count !== 16'd2)
            $display("FAIL b2b_second got valid=%0b data=%0d count=%0d want 1 3 2",
                     m_if.out_valid, $signed(m_if.out_data), m_if.out_count);
        else n_pass++;
        step();
        m_if.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_group();
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (m_if.state !== ACCUM || m_if.out_valid !== 1'b0)
            $display("FAIL midreset_state got state=%0d valid=%0b want %0d 0",
                     m_if.state, m_if.out_valid, ACCUM);
        else n_pass++;
        send(16'd4, 1'b1);
        step();
        n_checks++;
        if (m_if.out_valid !== 1'b1 || m_if.out_data !== 32'd4 || m_if.out_count !== 16'd1)
            $display("FAIL midreset_result got valid=%0b data=%0d count=%0d want 1 4 1",
                     m_if.out_valid, $signed(m_if.out_data), m_if.out_count);
        else n_pass++;
        handshake();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        m_if.in_data = '0; m_if.in_valid = 1'b0; m_if.in_last = 1'b0; m_if.out_ready = 1'b0;
        s_if.in_data = '0; s_if.in_valid = 1'b0; s_if.in_last = 1'b0; s_if.out_ready = 1'b0;
        t_if.in_data = '0; t_if.in_valid = 1'b0; t_if.in_last = 1'b0; t_if.out_ready = 1'b0;

        test_reset();
        test_plain_group();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_group();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
